text_writer: RTL and testbench

- Writer side of the text-mode video memory: accepts a stream of character/attribute bytes and writes them into the shared 128K video RAM at the cursor cell.
- Owns the cursor position that the video adapter reads. Handles CR, LF, BS and form-feed control codes.
- Scrolls the screen up by one row on overflow, using a read-copy-write pass over video RAM.
- Sits between the CPU I/O port logic and the write port of the video RAM.

---
 rtl/text_writer_if.sv | 34 +++
 rtl/text_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_text_writer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_if.sv
// Byte-stream input and video RAM write-port bundle for the text-mode writer.
// The master side is the writer itself; the slave side is the producer plus the RAM.
interface text_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_attr;
    logic [16:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport master (
        input  in_valid,
        input  in_char,
        input  in_attr,
        input  mem_rdata,
        output in_ready,
        output mem_address,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        output in_valid,
        output in_char,
        output in_attr,
        output mem_rdata,
        input  in_ready,
        input  mem_address,
        input  mem_wdata,
        input  mem_we
    );
endinterface

// File: rtl/text_writer.sv
// Text-mode video memory writer: places char/attr pairs at the cursor, handles CR/LF/BS/FF
// and scrolls the screen up one row with a read-copy-write pass when it overflows.
module text_writer #(
    parameter logic [16:0] BASE = 17'h00000,
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 25,
    parameter logic [7:0]  FILL = 8'h20
) (
    input  logic          clock,
    input  logic          reset_n,
    text_writer_if.master bus,
    output logic [10:0]   cursor,
    output logic          busy
);

    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [10:0]     LastCell    = 11'(COLS * ROWS - 1);
    localparam logic [10:0]     LastRowCell = 11'(COLS * (ROWS - 1));
    localparam logic [10:0]     ColsCells   = 11'(COLS);
    localparam logic [16:0]     RowBytes    = 17'(2 * COLS);
    localparam logic [16:0]     CopyLast    = 17'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [16:0]     ByteLast    = 17'(2 * COLS * ROWS - 1);
    localparam logic [ColW-1:0] ColLast     = ColW'(COLS - 1);
    localparam logic [RowW-1:0] RowLast     = RowW'(ROWS - 1);
    localparam int unsigned     EndAddr     = int'(BASE) + 2 * COLS * ROWS;

    localparam logic [7:0] CharBs = 8'h08;
    localparam logic [7:0] CharLf = 8'h0A;
    localparam logic [7:0] CharFf = 8'h0C;
    localparam logic [7:0] CharCr = 8'h0D;

    typedef enum logic [2:0] {
        StIdle,
        StPutChar,
        StPutAttr,
        StScrRd,
        StScrWait,
        StScrWr,
        StClrChar,
        StClrAttr
    } state_e;

    state_e          state_q, state_d;
    logic [10:0]     cursor_q, cursor_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [7:0]      char_q, char_d;
    logic [7:0]      attr_q, attr_d;
    logic [16:0]     off_q, off_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ff_q, ff_d;

    logic            accept;
    logic [16:0]     cell_addr;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign cell_addr = BASE + 17'({cursor_q, 1'b0});
    assign cursor    = cursor_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.in_char)
                        CharCr, CharBs: state_d = StIdle;
                        CharLf:         state_d = (row_q == RowLast) ? StScrRd : StIdle;
                        CharFf:         state_d = StClrChar;
                        default:        state_d = StPutChar;
                    endcase
                end
            end
            StPutChar: state_d = StPutAttr;
            StPutAttr: state_d = (cursor_q == LastCell) ? StScrRd : StIdle;
            StScrRd:   state_d = StScrWait;
            StScrWait: state_d = StScrWr;
            StScrWr:   state_d = (off_q == CopyLast) ? StClrChar : StScrRd;
            StClrChar: state_d = StClrAttr;
            StClrAttr: state_d = (off_q == ByteLast) ? StIdle : StClrChar;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == StIdle);
        busy            = (state_q != StIdle);
        bus.mem_we      = 1'b0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        unique case (state_q)
            StPutChar: begin
                bus.mem_we      = 1'b1;
                bus.mem_address = cell_addr;
                bus.mem_wdata   = char_q;
            end
            StPutAttr: begin
                bus.mem_we      = 1'b1;
                bus.mem_address = cell_addr + 17'd1;
                bus.mem_wdata   = attr_q;
            end
            StScrRd, StScrWait: begin
                bus.mem_address = BASE + off_q + RowBytes;
            end
            StScrWr: begin
                bus.mem_we      = 1'b1;
                bus.mem_address = BASE + off_q;
                bus.mem_wdata   = rdata_q;
            end
            StClrChar: begin
                bus.mem_we      = 1'b1;
                bus.mem_address = BASE + off_q;
                bus.mem_wdata   = FILL;
            end
            StClrAttr: begin
                bus.mem_we      = 1'b1;
                bus.mem_address = BASE + off_q;
                bus.mem_wdata   = attr_q;
            end
            default: ;
        endcase
    end

    // Row and column are tracked alongside the linear cursor to avoid a divide by COLS.
    always_comb begin
        cursor_d = cursor_q;
        row_d    = row_q;
        col_d    = col_q;
        char_d   = char_q;
        attr_d   = attr_q;
        off_d    = off_q;
        rdata_d  = rdata_q;
        ff_d     = ff_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    char_d = bus.in_char;
                    attr_d = bus.in_attr;
                    off_d  = '0;
                    case (bus.in_char)
                        CharCr: begin
                            cursor_d = cursor_q - 11'(col_q);
                            col_d    = '0;
                        end
                        CharLf: begin
                            if (row_q != RowLast) begin
                                cursor_d = cursor_q - 11'(col_q) + ColsCells;
                                row_d    = row_q + RowW'(1);
                                col_d    = '0;
                            end else begin
                                ff_d = 1'b0;
                            end
                        end
                        CharBs: begin
                            if (col_q != '0) begin
                                cursor_d = cursor_q - 11'd1;
                                col_d    = col_q - ColW'(1);
                            end
                        end
                        CharFf:  ff_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StPutAttr: begin
                if (cursor_q == LastCell) begin
                    ff_d = 1'b0;
                end else begin
                    cursor_d = cursor_q + 11'd1;
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = row_q + RowW'(1);
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StScrWait: rdata_d = bus.mem_rdata;
            StScrWr, StClrChar: off_d = off_q + 17'd1;
            StClrAttr: begin
                if (off_q == ByteLast) begin
                    // A full-screen clear homes the cursor; a scroll parks it on the last row.
                    cursor_d = ff_q ? 11'd0 : LastRowCell;
                    row_d    = ff_q ? '0 : RowLast;
                    col_d    = '0;
                end else begin
                    off_d = off_q + 17'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cursor_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            char_q   <= '0;
            attr_q   <= '0;
            off_q    <= '0;
            rdata_q  <= '0;
            ff_q     <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
            row_q    <= row_d;
            col_q    <= col_d;
            char_q   <= char_d;
            attr_q   <= attr_d;
            off_q    <= off_d;
            rdata_q  <= rdata_d;
            ff_q     <= ff_d;
        end
    end

    // The screen window must fit inside the 128K video RAM.
    a_window_fits: assert property (@(posedge clock) EndAddr <= 32'h20000);

    a_cursor_range: assert property (@(posedge clock) disable iff (!reset_n)
        cursor_q <= LastCell);

    a_we_only_busy: assert property (@(posedge clock) disable iff (!reset_n)
        bus.mem_we |-> busy);

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: a cell-level reference model predicts every RAM write,
// busy span and cursor value, and a per-cycle compare process checks the DUT against it.
module tb_text_writer;
    localparam int COLS = 80;
    localparam int ROWS = 25;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] cursor;
    logic        busy;

    text_writer_if bus ();

    text_writer dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .cursor (cursor),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    // Video RAM: synchronous read, data one cycle after the address.
    logic [7:0] sim_mem [0:131071];
    logic       preload_req = 1'b0;
    always @(posedge clock) begin
        if (preload_req) begin
            for (int i = 0; i < 2 * COLS * ROWS; i++) sim_mem[i] <= 8'(i);
        end else if (bus.mem_we) begin
            sim_mem[bus.mem_address] <= bus.mem_wdata;
        end
        bus.mem_rdata <= sim_mem[bus.mem_address];
    end

    int total = 0;
    int bad   = 0;

    int mcur      = 0;
    int pend_cur  = 0;
    int busy_left = 0;
    int exp_addr[$];
    int exp_data[$];
    int mdl_mem [0:3999];
    int cmt_mem [0:3999];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(int addr, int data);
        exp_addr.push_back(addr);
        exp_data.push_back(data & 255);
        mdl_mem[addr] = data & 255;
    endfunction

    function automatic void model_scroll(int a);
        for (int k = 0; k < 2 * COLS * (ROWS - 1); k++) push(k, mdl_mem[k + 2 * COLS]);
        for (int k = 2 * COLS * (ROWS - 1); k < 2 * COLS * ROWS; k++)
            push(k, (k % 2 == 0) ? 32'h20 : a);
        busy_left += 3 * 2 * COLS * (ROWS - 1) + 2 * COLS;
        pend_cur = COLS * (ROWS - 1);
    endfunction

    function automatic void model_accept(int c, int a);
        int row;
        int col;
        row = mcur / COLS;
        col = mcur % COLS;
        case (c)
            'h0D: mcur = row * COLS;
            'h0A: begin
                if (row < ROWS - 1) mcur = (row + 1) * COLS;
                else model_scroll(a);
            end
            'h08: if (col > 0) mcur = mcur - 1;
            'h0C: begin
                for (int i = 0; i < COLS * ROWS; i++) begin
                    push(2 * i, 'h20);
                    push(2 * i + 1, a);
                end
                busy_left = 2 * COLS * ROWS;
                pend_cur  = 0;
            end
            default: begin
                push(2 * mcur, c);
                push(2 * mcur + 1, a);
                busy_left = 2;
                if (mcur == COLS * ROWS - 1) model_scroll(a);
                else pend_cur = mcur + 1;
            end
        endcase
    endfunction

    function automatic void abort_model();
        exp_addr.delete();
        exp_data.delete();
        busy_left = 0;
        mcur      = 0;
        for (int i = 0; i < 2 * COLS * ROWS; i++) mdl_mem[i] = cmt_mem[i];
    endfunction

    always @(negedge clock) begin : cmp
        int ea;
        int ed;
        if (reset_n) begin
            chk("busy", int'(busy), int'(busy_left != 0));
            chk("in_ready", int'(bus.in_ready), int'(busy_left == 0));
            chk("cursor", int'(cursor), mcur);
            if (bus.mem_we) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_we_addr", int'(bus.mem_address), -1);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    chk("wr_addr", int'(bus.mem_address), ea);
                    chk("wr_data", int'(bus.mem_wdata), ed);
                    cmt_mem[ea] = ed;
                end
            end
            if (busy_left != 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    mcur = pend_cur;
                    chk("writes_left", exp_addr.size(), 0);
                end
            end else if (bus.in_valid) begin
                model_accept(int'(bus.in_char), int'(bus.in_attr));
            end
        end
    end

    task automatic send(input int c, input int a, input bit hold);
        int n;
        n = 0;
        bus.in_char  = 8'(c);
        bus.in_attr  = 8'(a);
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            n++;
            if (n > 20000) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock);
        #2;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cyc, output int we_cyc);
        busy_cyc = 0;
        we_cyc   = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            busy_cyc++;
            if (bus.mem_we) we_cyc++;
            if (busy_cyc > 20000) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock);
        #2;
    endtask

    initial begin
        int bc;
        int wc;
        int nbad;
        int n;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.in_attr  = '0;
        for (int i = 0; i < 2 * COLS * ROWS; i++) begin
            mdl_mem[i] = 0;
            cmt_mem[i] = 0;
        end
        repeat (3) @(posedge clock);
        #2;
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        chk("rst_we", int'(bus.mem_we), 0);
        chk("rst_addr", int'(bus.mem_address), 0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        reset_n = 1'b1;

        send('h41, 'h1F, 1'b0);
        wait_idle(bc, wc);
        chk("A_ready_low_cycles", bc, 2);
        chk("A_char", int'(sim_mem[0]), 'h41);
        chk("A_attr", int'(sim_mem[1]), 'h1F);
        chk("A_cursor", int'(cursor), 1);

        send('h0A, 'h07, 1'b0);
        for (int i = 0; i < 5; i++) send('h61 + i, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("pos85", int'(cursor), 85);
        send('h0D, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("cr_cursor", int'(cursor), 80);
        chk("cr_busy", bc, 0);
        chk("cr_no_we", wc, 0);
        send('h08, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("bs_col0_cursor", int'(cursor), 80);
        send('h0A, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("lf_cursor", int'(cursor), 160);

        send('h0C, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("ff_we_cycles", wc, 4000);
        chk("ff_cursor", int'(cursor), 0);
        nbad = 0;
        for (int i = 0; i < 4000; i++)
            if (int'(sim_mem[i]) != ((i % 2 == 0) ? 'h20 : 'h07)) nbad++;
        chk("ff_bad_bytes", nbad, 0);

        send('h70, 'h11, 1'b1);
        send('h71, 'h12, 1'b1);
        send('h72, 'h13, 1'b0);
        wait_idle(bc, wc);
        chk("b2b_cursor", int'(cursor), 3);
        chk("b2b_c0", int'(sim_mem[0]), 'h70);
        chk("b2b_a0", int'(sim_mem[1]), 'h11);
        chk("b2b_c1", int'(sim_mem[2]), 'h71);
        chk("b2b_a1", int'(sim_mem[3]), 'h12);
        chk("b2b_c2", int'(sim_mem[4]), 'h72);
        chk("b2b_a2", int'(sim_mem[5]), 'h13);

        for (int i = 0; i < 40; i++) begin
            int r;
            int c;
            int g;
            r = $urandom_range(0, 9);
            c = (r == 0) ? 'h0D : (r == 1) ? 'h0A : (r == 2) ? 'h08 : $urandom_range('h21, 'h7E);
            send(c, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            g = $urandom_range(0, 2);
            if (g > 0) begin
                repeat (g) @(posedge clock);
                #2;
            end
        end
        bus.in_valid = 1'b0;
        wait_idle(bc, wc);
        chk("rand_writes_drained", exp_addr.size(), 0);

        send('h0C, 'h07, 1'b0);
        for (int i = 0; i < ROWS - 1; i++) send('h0A, 'h07, 1'b0);
        for (int i = 0; i < COLS - 1; i++) send('h30, 'h07, 1'b0);
        wait_idle(bc, wc);
        chk("pos1999", int'(cursor), 1999);
        preload_req = 1'b1;
        @(posedge clock);
        #2;
        preload_req = 1'b0;
        for (int i = 0; i < 2 * COLS * ROWS; i++) begin
            mdl_mem[i] = i & 255;
            cmt_mem[i] = i & 255;
        end
        send('h5A, 'h4E, 1'b0);
        wait_idle(bc, wc);
        chk("z_busy_cycles", bc, 11682);
        chk("scr_byte0", int'(sim_mem[0]), 'hA0);
        chk("scr_byte1000", int'(sim_mem[1000]), 'h88);
        chk("scr_byte3679", int'(sim_mem[3679]), 'hFF);
        chk("scr_z_char", int'(sim_mem[3838]), 'h5A);
        chk("scr_z_attr", int'(sim_mem[3839]), 'h4E);
        nbad = 0;
        for (int i = 3840; i < 4000; i++)
            if (int'(sim_mem[i]) != ((i % 2 == 0) ? 'h20 : 'h4E)) nbad++;
        chk("scr_lastrow_bad_bytes", nbad, 0);
        chk("scr_cursor", int'(cursor), 1920);

        send('h0A, 'h33, 1'b0);
        repeat (500) @(negedge clock);
        n = 0;
        while (!bus.mem_we && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("mid_scroll_we", int'(bus.mem_we), 1);
        #1;
        reset_n = 1'b0;
        abort_model();
        #1;
        chk("abort_we", int'(bus.mem_we), 0);
        chk("abort_cursor", int'(cursor), 0);
        chk("abort_busy", int'(busy), 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        chk("post_rst_ready", int'(bus.in_ready), 1);
        send('h42, 'h2A, 1'b0);
        wait_idle(bc, wc);
        chk("B_char", int'(sim_mem[0]), 'h42);
        chk("B_attr", int'(sim_mem[1]), 'h2A);
        chk("B_cursor", int'(cursor), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
